// File: rtl/pad_mux_pkg.sv
// Shared types and constants for the pad multiplexing controller.
package pad_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    APPLY = 2'd2
  } state_e;

  localparam int unsigned CFG_DIR_BIT   = 0;
  // Reset cfg value: direction bit set (input/tristate), all others clear.
  localparam int unsigned CFG_RESET_VAL = 1;
  localparam int unsigned CNT_W         = 4;

endpackage

// File: rtl/pad_mux_slice.sv
// Per-pad data path: selects the owning source's data/enable toward the pad,
// gates drive by direction and turnaround, and returns TO_CORE to the owner.
module pad_mux_slice
  import pad_mux_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned CONF_WIDTH = 3,
  parameter int unsigned SRC_W      = 2
) (
  input  logic [SRC_W-1:0]      owner,
  input  logic [CONF_WIDTH-1:0] cfg_reg,
  input  logic                  turn,
  input  logic [NUM_SRC-1:0]    src_out,
  input  logic [NUM_SRC-1:0]    src_oe,
  input  logic                  pad_to_core,
  output logic [NUM_SRC-1:0]    src_in_c,
  output logic                  pad_from_core_c,
  output logic [CONF_WIDTH-1:0] pad_cfg_c
);

  logic owned;
  logic sel_out;
  logic sel_oe;
  logic drive;

  // Owner 0 means unowned: it selects nothing and never drives or receives.
  always_comb begin
    owned    = |owner;
    sel_out  = 1'b0;
    sel_oe   = 1'b0;
    src_in_c = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (owner == SRC_W'(s)) begin
        sel_out     = src_out[s];
        sel_oe      = src_oe[s];
        src_in_c[s] = pad_to_core & owned & ~turn;
      end
    end
    drive           = owned & sel_oe & ~cfg_reg[CFG_DIR_BIT] & ~turn;
    pad_from_core_c = drive & sel_out;
    pad_cfg_c       = cfg_reg;
    pad_cfg_c[CFG_DIR_BIT] = ~drive;
  end

endmodule

// File: rtl/pad_mux_ctrl.sv
// Pad ownership/config controller with forced-tristate turnaround on every change.
// Optional per-pad lock enabled by defining PAD_MUX_CTRL_LOCK_EN.
module pad_mux_ctrl
  import pad_mux_pkg::*;
#(
  parameter int unsigned NUM_PADS    = 8,
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned CONF_WIDTH  = 3,
  parameter int unsigned TURN_CYCLES = 2
) (
  input  logic                             clk_in,
  input  logic                             reset_n_in,
  input  logic                             cfg_req,
  output logic                             cfg_gnt,
  input  logic [$clog2(NUM_PADS)-1:0]      cfg_pad,
  input  logic [$clog2(NUM_SRC)-1:0]       cfg_src,
  input  logic [CONF_WIDTH-1:0]            cfg_bits,
  output logic                             cfg_done,
  output logic                             cfg_err,
  output logic                             busy,
  input  logic [NUM_SRC*NUM_PADS-1:0]      src_out,
  input  logic [NUM_SRC*NUM_PADS-1:0]      src_oe,
  output logic [NUM_SRC*NUM_PADS-1:0]      src_in,
  output logic [NUM_PADS-1:0]              pad_from_core,
  input  logic [NUM_PADS-1:0]              pad_to_core,
  output logic [NUM_PADS*CONF_WIDTH-1:0]   pad_cfg
);

  localparam int unsigned PAD_W     = $clog2(NUM_PADS);
  localparam int unsigned SRC_W     = $clog2(NUM_SRC);
  localparam int unsigned PAD_RANGE = 1 << PAD_W;
  localparam int unsigned SRC_RANGE = 1 << SRC_W;
  // Index-validity masks avoid range compares that are constant at power-of-two sizes.
  localparam logic [PAD_RANGE-1:0] PAD_VALID = {PAD_RANGE{1'b1}} >> (PAD_RANGE - NUM_PADS);
  localparam logic [SRC_RANGE-1:0] SRC_VALID = {SRC_RANGE{1'b1}} >> (SRC_RANGE - NUM_SRC);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PAD_W-1:0]      lat_pad_q;
  logic [SRC_W-1:0]      lat_src_q;
  logic [CONF_WIDTH-1:0] lat_bits_q;
  logic                  lat_we_c;
  logic                  apply_c;
  logic                  done_d;
  logic                  err_d;
  logic                  req_ok_c;
  logic                  locked_c;

  logic [SRC_W-1:0]      owner_q [NUM_PADS];
  logic [CONF_WIDTH-1:0] cfg_q   [NUM_PADS];

`ifdef PAD_MUX_CTRL_LOCK_EN
  logic [PAD_RANGE-1:0] lock_q;

  assign locked_c = lock_q[cfg_pad];

  // Sticky lock, cleared only by reset.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      lock_q <= '0;
    end else if (apply_c && lat_bits_q[CONF_WIDTH-1]) begin
      lock_q[lat_pad_q] <= 1'b1;
    end
  end
`else
  assign locked_c = 1'b0;
`endif

  assign req_ok_c = PAD_VALID[cfg_pad] & SRC_VALID[cfg_src] & ~locked_c;

  // Next-state and pulse generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lat_we_c = 1'b0;
    apply_c  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_req) begin
          if (!req_ok_c) begin
            err_d = 1'b1;
          end else begin
            lat_we_c = 1'b1;
            cnt_d    = CNT_W'(TURN_CYCLES - 1);
            state_d  = TURN;
          end
        end
      end
      TURN: begin
        if (cnt_q == '0) begin
          state_d = APPLY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      APPLY: begin
        apply_c = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_pad_q  <= '0;
      lat_src_q  <= '0;
      lat_bits_q <= '0;
      cfg_gnt    <= 1'b1;
      busy       <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cfg_gnt  <= (state_d == IDLE);
      busy     <= (state_d != IDLE);
      cfg_done <= done_d;
      cfg_err  <= err_d;
      if (lat_we_c) begin
        lat_pad_q  <= cfg_pad;
        lat_src_q  <= cfg_src;
        lat_bits_q <= cfg_bits;
      end
    end
  end

  // Per-pad ownership and configuration, written only in APPLY.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      for (int unsigned p = 0; p < NUM_PADS; p++) begin
        owner_q[p] <= '0;
        cfg_q[p]   <= CONF_WIDTH'(CFG_RESET_VAL);
      end
    end else if (apply_c) begin
      for (int unsigned p = 0; p < NUM_PADS; p++) begin
        if (lat_pad_q == PAD_W'(p)) begin
          owner_q[p] <= lat_src_q;
          cfg_q[p]   <= lat_bits_q;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic [NUM_SRC-1:0] out_col;
    logic [NUM_SRC-1:0] oe_col;
    logic [NUM_SRC-1:0] in_col;
    logic               turn;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      assign out_col[s]              = src_out[s*NUM_PADS+p];
      assign oe_col[s]               = src_oe[s*NUM_PADS+p];
      assign src_in[s*NUM_PADS+p]    = in_col[s];
    end

    // The latched pad stays tristate from acceptance through APPLY.
    assign turn = (state_q != IDLE) && (lat_pad_q == PAD_W'(p));

    pad_mux_slice #(
      .NUM_SRC    (NUM_SRC),
      .CONF_WIDTH (CONF_WIDTH),
      .SRC_W      (SRC_W)
    ) u_slice (
      .owner           (owner_q[p]),
      .cfg_reg         (cfg_q[p]),
      .turn            (turn),
      .src_out         (out_col),
      .src_oe          (oe_col),
      .pad_to_core     (pad_to_core[p]),
      .src_in_c        (in_col),
      .pad_from_core_c (pad_from_core[p]),
      .pad_cfg_c       (pad_cfg[p*CONF_WIDTH +: CONF_WIDTH])
    );
  end

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// Directed bench for pad_mux_ctrl: table-driven data-path vectors plus
// hand-written sequences for turnaround, errors, back-to-back, reset and lock.
module tb_pad_mux_ctrl;

  // Six pads / three sources so out-of-range pad and source indices are encodable.
  localparam int unsigned NP = 6;
  localparam int unsigned NS = 3;
  localparam int unsigned CW = 3;
  localparam int unsigned TC = 2;
  localparam int unsigned PW = 3;
  localparam int unsigned SW = 2;

  localparam logic [17:0] CFG_RST = 18'h09249;
  localparam logic [17:0] B_CFG   = 18'b001_001_001_001_011_001;
  localparam logic [17:0] P3_CFG  = 18'b001_001_000_001_011_001;
  localparam logic [17:0] P34_CFG = 18'b001_000_000_001_011_001;

  logic              clk_in = 1'b0;
  logic              reset_n_in;
  logic              cfg_req;
  logic              cfg_gnt;
  logic [PW-1:0]     cfg_pad;
  logic [SW-1:0]     cfg_src;
  logic [CW-1:0]     cfg_bits;
  logic              cfg_done;
  logic              cfg_err;
  logic              busy;
  logic [NS*NP-1:0]  src_out;
  logic [NS*NP-1:0]  src_oe;
  logic [NS*NP-1:0]  src_in;
  logic [NP-1:0]     pad_from_core;
  logic [NP-1:0]     pad_to_core;
  logic [NP*CW-1:0]  pad_cfg;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [17:0] so;
    logic [17:0] oe;
    logic [5:0]  tc;
    logic [5:0]  efc;
    logic [17:0] ecfg;
    logic [17:0] ein;
  } vec_t;

  vec_t vt [8];

  always #5 clk_in = ~clk_in;

  pad_mux_ctrl #(
    .NUM_PADS    (NP),
    .NUM_SRC     (NS),
    .CONF_WIDTH  (CW),
    .TURN_CYCLES (TC)
  ) dut (
    .clk_in        (clk_in),
    .reset_n_in    (reset_n_in),
    .cfg_req       (cfg_req),
    .cfg_gnt       (cfg_gnt),
    .cfg_pad       (cfg_pad),
    .cfg_src       (cfg_src),
    .cfg_bits      (cfg_bits),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err),
    .busy          (busy),
    .src_out       (src_out),
    .src_oe        (src_oe),
    .src_in        (src_in),
    .pad_from_core (pad_from_core),
    .pad_to_core   (pad_to_core),
    .pad_cfg       (pad_cfg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_in);
      if (cfg_done) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  // One full change request with turnaround checks on the target pad
  // and on every other pad (which must not be disturbed).
  task automatic run_txn(input int pad, input int src, input logic [2:0] bits);
    logic [NP-1:0]    fc_snap;
    logic [NS*NP-1:0] in_snap;
    logic [NP-1:0]    fmask;
    logic [NS*NP-1:0] imask;
    fmask = '0;
    imask = '0;
    fmask[pad] = 1'b1;
    for (int s = 0; s < int'(NS); s++) imask[s*NP+pad] = 1'b1;
    @(negedge clk_in);
    chk("gnt_before", 32'(cfg_gnt), 32'd1);
    cfg_req  = 1'b1;
    cfg_pad  = PW'(pad);
    cfg_src  = SW'(src);
    cfg_bits = bits;
    fc_snap  = pad_from_core;
    in_snap  = src_in;
    @(posedge clk_in);
    #1;
    cfg_req  = 1'b0;
    cfg_pad  = ~cfg_pad;
    cfg_src  = ~cfg_src;
    cfg_bits = ~bits;
    for (int i = 1; i <= int'(TC) + 1; i++) begin
      @(negedge clk_in);
      chk("turn_fc", 32'(pad_from_core[pad]), 32'd0);
      chk("turn_dir", 32'(pad_cfg[pad*CW]), 32'd1);
      chk("turn_in", 32'(src_in & imask), 32'd0);
      chk("turn_gnt", 32'(cfg_gnt), 32'd0);
      chk("turn_busy", 32'(busy), 32'd1);
      chk("turn_done", 32'(cfg_done), 32'd0);
      chk("other_fc", 32'(pad_from_core & ~fmask), 32'(fc_snap & ~fmask));
      chk("other_in", 32'(src_in & ~imask), 32'(in_snap & ~imask));
    end
    @(negedge clk_in);
    chk("done_pulse", 32'(cfg_done), 32'd1);
    chk("done_gnt", 32'(cfg_gnt), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("cfg_upper", 32'(pad_cfg[pad*CW+1 +: 2]), 32'(bits[2:1]));
    @(negedge clk_in);
    chk("done_clear", 32'(cfg_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP*CW-1:0] cfg_snap;
    logic [NP-1:0]    fc_snap;
    bit               seen;

    vt[0] = '{so:18'h0,     oe:18'h0,     tc:6'b000000, efc:6'b000000, ecfg:B_CFG,   ein:18'h0};
    vt[1] = '{so:18'h08000, oe:18'h08000, tc:6'b000000, efc:6'b001000, ecfg:P3_CFG,  ein:18'h0};
    vt[2] = '{so:18'h0,     oe:18'h08000, tc:6'b000000, efc:6'b000000, ecfg:P3_CFG,  ein:18'h0};
    vt[3] = '{so:18'h00400, oe:18'h08400, tc:6'b000000, efc:6'b010000, ecfg:P34_CFG, ein:18'h0};
    vt[4] = '{so:18'h11200, oe:18'h11200, tc:6'b000000, efc:6'b000000, ecfg:B_CFG,   ein:18'h0};
    vt[5] = '{so:18'h02000, oe:18'h02000, tc:6'b000000, efc:6'b000000, ecfg:B_CFG,   ein:18'h0};
    vt[6] = '{so:18'h0,     oe:18'h0,     tc:6'b111111, efc:6'b000000, ecfg:B_CFG,   ein:18'h0A400};
    vt[7] = '{so:18'h08000, oe:18'h08000, tc:6'b010010, efc:6'b001000, ecfg:P3_CFG,  ein:18'h02400};

    reset_n_in  = 1'b0;
    cfg_req     = 1'b0;
    cfg_pad     = '0;
    cfg_src     = '0;
    cfg_bits    = '0;
    src_out     = '1;
    src_oe      = '1;
    pad_to_core = '1;

    // Reset state, with all sources trying to drive and all pads high.
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    @(negedge clk_in);
    chk("rst_pad_cfg", 32'(pad_cfg), 32'(CFG_RST));
    chk("rst_fc", 32'(pad_from_core), 32'd0);
    chk("rst_src_in", 32'(src_in), 32'd0);
    chk("rst_gnt", 32'(cfg_gnt), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(cfg_done), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);

    // Pad 3 to source 2, driving a 1.
    src_out     = 18'h08000;
    src_oe      = 18'h08000;
    pad_to_core = '0;
    run_txn(3, 2, 3'b000);
    chk("p3_fc", 32'(pad_from_core), 32'b001000);
    chk("p3_cfg", 32'(pad_cfg), 32'(18'b001_001_000_001_001_001));

    run_txn(4, 1, 3'b000);
    run_txn(1, 2, 3'b011);

    // Steady-state data-path vectors.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      src_out     = vt[i].so;
      src_oe      = vt[i].oe;
      pad_to_core = vt[i].tc;
      #1;
      chk($sformatf("vec%0d_fc", i), 32'(pad_from_core), 32'(vt[i].efc));
      chk($sformatf("vec%0d_cfg", i), 32'(pad_cfg), 32'(vt[i].ecfg));
      chk($sformatf("vec%0d_in", i), 32'(src_in), 32'(vt[i].ein));
    end

    // Reassign pad 3 from source 2 to source 1 while pad 4 keeps running.
    @(negedge clk_in);
    src_out     = 18'h08600;
    src_oe      = 18'h08600;
    pad_to_core = 6'b011000;
    #1;
    chk("re_pre_fc", 32'(pad_from_core), 32'b011000);
    chk("re_pre_in", 32'(src_in), 32'h08400);
    run_txn(3, 1, 3'b000);
    chk("re_post_fc", 32'(pad_from_core), 32'b011000);
    chk("re_post_in", 32'(src_in), 32'h00600);
    src_out = 18'h08400;
    #1;
    chk("re_owner_src1", 32'(pad_from_core), 32'b010000);

    // Out-of-range pad, then a valid request accepted the very next cycle.
    @(negedge clk_in);
    cfg_snap = pad_cfg;
    fc_snap  = pad_from_core;
    cfg_req  = 1'b1;
    cfg_pad  = 3'd7;
    cfg_src  = 2'd1;
    cfg_bits = 3'b000;
    @(posedge clk_in);
    #1;
    cfg_pad  = 3'd5;
    cfg_src  = 2'd1;
    cfg_bits = 3'b001;
    @(negedge clk_in);
    chk("bad_pad_err", 32'(cfg_err), 32'd1);
    chk("bad_pad_gnt", 32'(cfg_gnt), 32'd1);
    chk("bad_pad_busy", 32'(busy), 32'd0);
    chk("bad_pad_cfg", 32'(pad_cfg), 32'(cfg_snap));
    chk("bad_pad_fc", 32'(pad_from_core), 32'(fc_snap));
    @(posedge clk_in);
    #1;
    cfg_req = 1'b0;
    @(negedge clk_in);
    chk("after_err_busy", 32'(busy), 32'd1);
    chk("after_err_clear", 32'(cfg_err), 32'd0);
    wait_done("after_err_done");

    // Out-of-range source.
    @(negedge clk_in);
    cfg_snap = pad_cfg;
    cfg_req  = 1'b1;
    cfg_pad  = 3'd2;
    cfg_src  = 2'd3;
    @(posedge clk_in);
    #1;
    cfg_req = 1'b0;
    @(negedge clk_in);
    chk("bad_src_err", 32'(cfg_err), 32'd1);
    chk("bad_src_busy", 32'(busy), 32'd0);
    chk("bad_src_cfg", 32'(pad_cfg), 32'(cfg_snap));
    @(negedge clk_in);
    chk("bad_src_clear", 32'(cfg_err), 32'd0);

    // Back-to-back with cfg_req held; inputs change right after the first accept.
    pad_to_core = 6'b011100;
    @(negedge clk_in);
    cfg_req  = 1'b1;
    cfg_pad  = 3'd2;
    cfg_src  = 2'd1;
    cfg_bits = 3'b000;
    @(posedge clk_in);
    #1;
    cfg_src = 2'd2;
    for (int i = 1; i <= int'(TC) + 1; i++) begin
      @(negedge clk_in);
      chk("b2b_gnt_low", 32'(cfg_gnt), 32'd0);
      chk("b2b_turn_in", 32'(src_in[NP+2]), 32'd0);
    end
    @(negedge clk_in);
    chk("b2b_done1", 32'(cfg_done), 32'd1);
    chk("b2b_gnt_high", 32'(cfg_gnt), 32'd1);
    chk("b2b_first_owner", 32'(src_in[NP+2]), 32'd1);
    chk("b2b_not_src2", 32'(src_in[2*NP+2]), 32'd0);
    @(posedge clk_in);
    #1;
    cfg_req = 1'b0;
    @(negedge clk_in);
    chk("b2b_second_acc", 32'(busy), 32'd1);
    chk("b2b_done_clear", 32'(cfg_done), 32'd0);
    chk("b2b_turn2_in", 32'(src_in[NP+2]), 32'd0);
    wait_done("b2b_done2");
    chk("b2b_second_owner", 32'(src_in[2*NP+2]), 32'd1);
    chk("b2b_old_owner", 32'(src_in[NP+2]), 32'd0);

    // Reset asserted during TURN.
    @(negedge clk_in);
    cfg_req  = 1'b1;
    cfg_pad  = 3'd4;
    cfg_src  = 2'd2;
    cfg_bits = 3'b000;
    @(posedge clk_in);
    #1;
    cfg_req = 1'b0;
    @(negedge clk_in);
    chk("midrst_busy", 32'(busy), 32'd1);
    reset_n_in = 1'b0;
    @(posedge clk_in);
    #1;
    @(negedge clk_in);
    chk("midrst_cfg", 32'(pad_cfg), 32'(CFG_RST));
    chk("midrst_fc", 32'(pad_from_core), 32'd0);
    chk("midrst_in", 32'(src_in), 32'd0);
    chk("midrst_gnt", 32'(cfg_gnt), 32'd1);
    chk("midrst_busy0", 32'(busy), 32'd0);
    reset_n_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      if (cfg_done) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);

`ifdef PAD_MUX_CTRL_LOCK_EN
    // Lock pad 0, then a further request to it must be rejected until reset.
    pad_to_core = 6'b000001;
    run_txn(0, 1, 3'b100);
    @(negedge clk_in);
    cfg_req  = 1'b1;
    cfg_pad  = 3'd0;
    cfg_src  = 2'd2;
    cfg_bits = 3'b000;
    chk("lock_gnt", 32'(cfg_gnt), 32'd1);
    @(posedge clk_in);
    #1;
    cfg_req = 1'b0;
    @(negedge clk_in);
    chk("lock_err", 32'(cfg_err), 32'd1);
    chk("lock_busy", 32'(busy), 32'd0);
    chk("lock_owner_kept", 32'(src_in[NP]), 32'd1);
    chk("lock_not_src2", 32'(src_in[2*NP]), 32'd0);
    reset_n_in = 1'b0;
    @(negedge clk_in);
    reset_n_in = 1'b1;
    run_txn(0, 2, 3'b000);
    chk("unlock_owner", 32'(src_in[2*NP]), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
